// File: rtl/am_seg_assembler.sv
// Segment-to-vector assembler: gathers NUM_SEGS segments, lowest first, into one
// hypervector and hands it to the consumer with a valid/ready handshake.
module am_seg_assembler #(
    parameter int HV_DIM      = 5000,
    parameter int DIMS_PER_CC = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic [DIMS_PER_CC-1:0] seg_data,
    output logic [3:0]             seg_ctr,
    output logic                   hv_valid,
    input  logic                   hv_ready,
    output logic [HV_DIM-1:0]      hv_out
);
    localparam int         NUM_SEGS = HV_DIM / DIMS_PER_CC;
    localparam logic [3:0] LAST_SEG = 4'(NUM_SEGS - 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    generate
        if ((HV_DIM % DIMS_PER_CC) != 0 || NUM_SEGS < 1 || NUM_SEGS > 16) begin : g_bad_params
            $error("am_seg_assembler: HV_DIM must be a multiple of DIMS_PER_CC with 1..16 segments");
        end
    endgenerate

    logic [0:0]        state_q, state_d;
    logic [3:0]        seg_ctr_q, seg_ctr_d;
    logic [HV_DIM-1:0] hv_q, hv_d;
    logic              accept;

    assign seg_ready = (state_q == COLLECT);
    assign hv_valid  = (state_q == FULL);
    assign seg_ctr   = seg_ctr_q;
    assign hv_out    = hv_q;
    assign accept    = seg_valid & seg_ready;

    // Flush wins over both handshakes; the segment slot is chosen by a compare per
    // slot so only a plain write enable lands on each DIMS_PER_CC-wide field.
    always_comb begin
        state_d   = state_q;
        seg_ctr_d = seg_ctr_q;
        hv_d      = hv_q;
        if (flush) begin
            state_d   = COLLECT;
            seg_ctr_d = '0;
            hv_d      = '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                if (seg_ctr_q == 4'(i)) begin
                    hv_d[i*DIMS_PER_CC +: DIMS_PER_CC] = seg_data;
                end
            end
            if (seg_ctr_q == LAST_SEG) begin
                seg_ctr_d = '0;
                state_d   = FULL;
            end else begin
                seg_ctr_d = seg_ctr_q + 4'd1;
            end
        end else if (state_q == FULL && hv_ready) begin
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            seg_ctr_q <= '0;
            hv_q      <= '0;
        end else begin
            state_q   <= state_d;
            seg_ctr_q <= seg_ctr_d;
            hv_q      <= hv_d;
        end
    end

endmodule

// File: tb/tb_am_seg_assembler.sv
// Self-checking bench for am_seg_assembler: directed table, hand-written corner
// sequences and a randomized run against a segment-image reference model.
module tb_am_seg_assembler;
    localparam int HV = 5000;
    localparam int D  = 500;
    localparam int NS = HV / D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          seg_valid = 1'b0;
    logic          seg_ready;
    logic [D-1:0]  seg_data = '0;
    logic [3:0]    seg_ctr;
    logic          hv_valid;
    logic          hv_ready = 1'b0;
    logic [HV-1:0] hv_out;

    am_seg_assembler #(.HV_DIM(HV), .DIMS_PER_CC(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_data(seg_data),
        .seg_ctr(seg_ctr), .hv_valid(hv_valid), .hv_ready(hv_ready), .hv_out(hv_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: how many segments of the current vector have arrived, whether a
    // finished vector is waiting for the consumer, and the image built so far.
    bit            m_full;
    int            m_count;
    logic [HV-1:0] m_img;

    typedef struct {
        bit         sv;
        logic [9:0] k;
        bit         hr;
        bit         fl;
        int         exp_ctr;
        bit         exp_ready;
        bit         exp_valid;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [D-1:0] pat(input logic [9:0] k);
        return {50{k}};
    endfunction

    function automatic logic [D-1:0] rndSeg();
        logic [D-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[D-33:0], $urandom()};
        return r;
    endfunction

    task automatic modelReset();
        m_full  = 1'b0;
        m_count = 0;
        m_img   = '0;
    endtask

    task automatic modelStep(input bit sv, input logic [D-1:0] sd, input bit hr, input bit fl);
        if (fl) begin
            modelReset();
        end else if (!m_full && sv) begin
            m_img[m_count*D +: D] = sd;
            m_count++;
            if (m_count == NS) begin
                m_count = 0;
                m_full  = 1'b1;
            end
        end else if (m_full && hr) begin
            m_full = 1'b0;
        end
    endtask

    task automatic checkSmall(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkHv(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
        int first;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            first = 0;
            for (int s = NS - 1; s >= 0; s--) begin
                if (act[s*D +: D] !== exp[s*D +: D]) first = s;
            end
            $display("[TB] FAIL %s: segment %0d got %h expected %h", name, first,
                     act[first*D +: D], exp[first*D +: D]);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkSmall({tag, " seg_ready"}, 32'(seg_ready), 32'(!m_full));
        checkSmall({tag, " hv_valid"}, 32'(hv_valid), 32'(m_full));
        checkSmall({tag, " seg_ctr"}, 32'(seg_ctr), 32'(m_count));
        checkHv({tag, " hv_out"}, hv_out, m_img);
    endtask

    task automatic applyStimulus(input bit sv, input logic [D-1:0] sd, input bit hr, input bit fl);
        seg_valid = sv;
        seg_data  = sd;
        hv_ready  = hr;
        flush     = fl;
        @(posedge clk);
        modelStep(sv, sd, hr, fl);
        #1;
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        seg_valid = 1'b0;
        flush     = 1'b0;
        hv_ready  = 1'b0;
        seg_data  = '0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [HV-1:0] exp_vec;
    logic [HV-1:0] snap;
    logic [D-1:0]  ones_seg;
    logic [D-1:0]  a_seg;

    initial begin
        for (int k = 0; k < NS; k++) exp_vec[k*D +: D] = pat(10'(k));
        ones_seg = '1;
        a_seg    = {125{4'hA}};

        for (int i = 0; i < NS; i++) begin
            tbl[i] = '{1'b1, 10'(i), 1'b1, 1'b0, (i == NS - 1) ? 0 : i + 1, (i != NS - 1), (i == NS - 1)};
        end
        tbl[10] = '{1'b0, 10'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 10'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0};

        // Reset values and the basic ten-segment table
        resetDut();
        checkSmall("reset seg_ctr", 32'(seg_ctr), 32'd0);
        checkSmall("reset seg_ready", 32'(seg_ready), 32'd1);
        checkSmall("reset hv_valid", 32'(hv_valid), 32'd0);
        checkHv("reset hv_out", hv_out, '0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].sv, pat(tbl[i].k), tbl[i].hr, tbl[i].fl);
            checkSmall("tbl seg_ctr", 32'(seg_ctr), 32'(tbl[i].exp_ctr));
            checkSmall("tbl seg_ready", 32'(seg_ready), 32'(tbl[i].exp_ready));
            checkSmall("tbl hv_valid", 32'(hv_valid), 32'(tbl[i].exp_valid));
            if (i == NS - 1) checkHv("tbl hv_out", hv_out, exp_vec);
            checkOutput("tbl model");
        end

        // Gapped producer: valid toggles every cycle
        resetDut();
        for (int s = 0; s < 2 * NS; s++) begin
            applyStimulus((s % 2) == 0, pat(10'(s / 2)), 1'b1, 1'b0);
            checkOutput("gapped");
            if (s == 2 * NS - 2) checkHv("gapped hv_out", hv_out, exp_vec);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("gapped drain");

        // Consumer stalls for 5 cycles while the producer keeps a segment waiting
        for (int k = 0; k < NS; k++) begin
            applyStimulus(1'b1, rndSeg(), 1'b0, 1'b0);
            checkOutput("stall fill");
        end
        snap = m_img;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, pat(10'd77), 1'b0, 1'b0);
            checkSmall("stall seg_ready", 32'(seg_ready), 32'd0);
            checkSmall("stall hv_valid", 32'(hv_valid), 32'd1);
            checkHv("stall hv_out", hv_out, snap);
        end
        applyStimulus(1'b1, pat(10'd77), 1'b1, 1'b0);
        checkSmall("handoff seg_ready", 32'(seg_ready), 32'd1);
        checkSmall("handoff hv_valid", 32'(hv_valid), 32'd0);
        checkSmall("handoff seg_ctr", 32'(seg_ctr), 32'd0);
        applyStimulus(1'b1, pat(10'd77), 1'b0, 1'b0);
        snap[D-1:0] = pat(10'd77);
        checkSmall("held seg_ctr", 32'(seg_ctr), 32'd1);
        checkHv("held hv_out", hv_out, snap);

        // Flush after four segments, with a segment presented in the same cycle
        resetDut();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, pat(10'(k + 1)), 1'b1, 1'b0);
        applyStimulus(1'b1, pat(10'd5), 1'b1, 1'b1);
        checkSmall("flush seg_ctr", 32'(seg_ctr), 32'd0);
        checkSmall("flush hv_valid", 32'(hv_valid), 32'd0);
        checkSmall("flush seg_ready", 32'(seg_ready), 32'd1);
        checkHv("flush hv_out", hv_out, '0);
        for (int k = 0; k < NS; k++) applyStimulus(1'b1, pat(10'(k)), 1'b1, 1'b0);
        checkSmall("post-flush hv_valid", 32'(hv_valid), 32'd1);
        checkHv("post-flush hv_out", hv_out, exp_vec);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("post-flush drain");

        // Asynchronous reset while a finished vector is waiting
        for (int k = 0; k < NS; k++) applyStimulus(1'b1, pat(10'd3), 1'b0, 1'b0);
        checkSmall("pre-rst hv_valid", 32'(hv_valid), 32'd1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkSmall("async rst hv_valid", 32'(hv_valid), 32'd0);
        checkSmall("async rst seg_ready", 32'(seg_ready), 32'd1);
        checkSmall("async rst seg_ctr", 32'(seg_ctr), 32'd0);
        checkHv("async rst hv_out", hv_out, '0);
        seg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two back-to-back vectors with the consumer always ready
        begin
            int idx;
            int bubbles;
            int seen;
            bit acc;
            idx = 0;
            bubbles = 0;
            seen = 0;
            for (int c = 0; c < 40 && seen < 2; c++) begin
                acc = (idx < 2 * NS) && !m_full;
                if (idx < 2 * NS && !seg_ready) bubbles++;
                applyStimulus(idx < 2 * NS, (idx < NS) ? ones_seg : a_seg, 1'b1, 1'b0);
                if (acc) idx++;
                checkOutput("b2b");
                if (hv_valid) begin
                    checkHv("b2b vector", hv_out, (seen == 0) ? {NS{ones_seg}} : {NS{a_seg}});
                    seen++;
                end
            end
            checkSmall("b2b vectors seen", 32'(seen), 32'd2);
            checkSmall("b2b bubbles", 32'(bubbles), 32'd1);
        end

        // Randomized traffic against the reference image
        resetDut();
        begin
            bit           cur_sv;
            logic [D-1:0] cur_sd;
            bit           hr;
            bit           fl;
            bit           acc;
            cur_sv = 1'b1;
            cur_sd = rndSeg();
            for (int c = 0; c < 400; c++) begin
                hr  = ($urandom_range(0, 1) == 1);
                fl  = ($urandom_range(0, 39) == 0);
                acc = cur_sv && !m_full && !fl;
                applyStimulus(cur_sv, cur_sd, hr, fl);
                checkOutput("random");
                if (acc || !cur_sv || fl) begin
                    cur_sv = ($urandom_range(0, 3) != 0);
                    cur_sd = rndSeg();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/am_seg_assembler.md
Name: am_seg_assembler

Overview:
Segment-to-vector assembler. It is the inverse of the query segment slicer: it accepts one DIMS_PER_CC-bit hypervector segment per accepted handshake, lowest segment first. It places each segment into a full HV_DIM-bit register and presents the completed hypervector with a valid/ready handshake. It sits on the associative-memory output path, where class/result hypervectors return from the segment-serial datapath.

Parameters:
HV_DIM, 5000, full hypervector width in bits.
DIMS_PER_CC, 500, segment width in bits, processed per clock cycle.
NUM_SEGS, HV_DIM/DIMS_PER_CC (10), segments per hypervector. HV_DIM must be an exact multiple of DIMS_PER_CC; otherwise, elaboration error.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous abort of the current assembly.
seg_valid  in  1  seg_data holds a segment.
seg_ready  out  1  assembler can accept a segment.
seg_data  in  DIMS_PER_CC  segment payload.
seg_ctr  out  4  index of the next segment to be accepted (0..NUM_SEGS-1).
hv_valid  out  1  hv_out holds a complete hypervector.
hv_ready  in  1  consumer accepts hv_out.
hv_out  out  HV_DIM  assembled hypervector.

Behaviour:
- States: COLLECT, FULL. Reset state is COLLECT.
- Reset values:
  - seg_ctr=0
  - hv_out=0
  - hv_valid=0
  - seg_ready=1, since it is driven combinationally by the state.
- seg_ready = (state==COLLECT). hv_valid = (state==FULL), registered.
- Segment accept: accept = seg_valid & seg_ready.
  - On accept with seg_ctr=k, write hv_out[k*DIMS_PER_CC +: DIMS_PER_CC] <= seg_data.
  - All other bits of hv_out hold their value.
- Counter:
  - On accept with k < NUM_SEGS-1: seg_ctr <= k+1.
  - On accept with k == NUM_SEGS-1: seg_ctr <= 0 and state <= FULL.
  - seg_ctr never exceeds NUM_SEGS-1.
- Latency: hv_valid rises in the cycle after the 10th segment is accepted. That segment is already visible in hv_out in the same cycle.
- FULL state:
  - hv_out is stable and seg_ready=0; seg_valid is ignored.
  - When hv_ready=1, the transfer completes and state <= COLLECT.
  - seg_ready is 1 from the following cycle, giving one bubble per vector.
  - hv_out is not cleared on hand-off. It retains the previous contents until it is overwritten segment by segment.
- seg_valid with seg_ready=0: no write and no counter change. The producer must hold seg_data and seg_valid stable until accepted.
- hv_ready while hv_valid=0: ignored.
- flush=1 has priority over accept and hv_ready. On the next edge: seg_ctr <= 0, state <= COLLECT, hv_valid <= 0, hv_out <= 0. A segment presented in the same cycle is dropped.
- Reset asserted mid-assembly or in FULL: outputs return immediately (asynchronously) to their reset values. Partial data is lost.
- Back-to-back: a segment accepted on every cycle in COLLECT gives one vector every NUM_SEGS+1 cycles when hv_ready is held at 1.

Test Plan:
- Reset, then 10 back-to-back segments seg_data = {50{10'(k)}} for k=0..9 with hv_ready=1. Required response:
  - hv_valid is high for exactly one cycle, 1 cycle after the 10th accept.
  - hv_out[k*500 +: 500] == {50{10'(k)}} for every k.
  - seg_ctr returns to 0.
- Segments with seg_valid toggling 1,0,1,0,... Required response: seg_ctr increments only on cycles with valid=1, and the final hv_out matches the gap-free case.
- Complete a vector with hv_ready=0 for 5 cycles while seg_valid=1 is held. Required response:
  - seg_ready=0 and hv_out is unchanged throughout.
  - After hv_ready=1, seg_ready=1 on the next cycle and the held segment is written at index 0.
- Assert flush after 4 segments, concurrent with seg_valid=1. Required response:
  - The next cycle shows seg_ctr=0, hv_out=0, hv_valid=0, and the concurrent segment is dropped.
  - A following full 10-segment run assembles correctly.
- Assert rst asynchronously mid-cycle during FULL. Required response: hv_valid=0, seg_ready=1, seg_ctr=0 and hv_out=0 before the next clock edge.
- Two consecutive vectors (all-ones, then alternating 0xA pattern) with hv_ready=1. Required response: each vector is output intact, and there is exactly 1 bubble cycle between them.
